// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI SRAM master: serial opcodes and FSM state
// encoding.
// Build option: SPI_RAM_MODE_INIT_EN adds the MODE_INIT state.
package spi_ram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] SEQ_MODE = 8'h40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    ADDR      = 3'd2,
    DATA      = 3'd3,
`ifdef SPI_RAM_MODE_INIT_EN
    MODE_INIT = 3'd5,
`endif
    DESEL     = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sram_master_if.sv
// Host-side request/response bus of the SPI SRAM master.
//   addr_in, data_in        : word address and write data, captured on accept
//   start_read, start_write : single-cycle request strobes
//   data_out                : last read word (registered)
//   busy                    : transaction in progress
// master modport = requesting host, slave modport = spi_sram_master.
interface spi_sram_master_if #(
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ADDR_BITS        = 16
);
  logic [ADDR_BITS-1:0]          addr_in;
  logic [8*DATA_WIDTH_BYTES-1:0] data_in;
  logic                          start_read;
  logic                          start_write;
  logic [8*DATA_WIDTH_BYTES-1:0] data_out;
  logic                          busy;

  modport master (
    output addr_in, data_in, start_read, start_write,
    input  data_out, busy
  );

  modport slave (
    input  addr_in, data_in, start_read, start_write,
    output data_out, busy
  );
endinterface

// File: rtl/spi_bit_shifter.sv
// Frame shift register for the SPI SRAM master.
//   load/load_word/load_bits : parallel load of a frame and its bit count
//   sample/miso              : shift left one bit, capturing miso at the LSB
//   mosi_bit                 : bit currently being presented (frame MSB)
//   bits_left                : bits not yet sampled
//   rx_word                  : the last RX_BITS bits received
// The same register serves TX and RX: every sample pushes one transmitted
// bit out of the top and one received bit into the bottom.
module spi_bit_shifter #(
  parameter int FRAME_BITS = 40,
  parameter int CNT_W      = 6,
  parameter int RX_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_word,
  input  logic [CNT_W-1:0]      load_bits,
  input  logic                  sample,
  input  logic                  miso,
  output logic                  mosi_bit,
  output logic [CNT_W-1:0]      bits_left,
  output logic [RX_BITS-1:0]    rx_word
);

  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk) begin
    if (load) begin
      sr <= load_word;
    end else if (sample) begin
      sr <= {sr[FRAME_BITS-2:0], miso};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_bits;
    end else if (sample && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign mosi_bit  = sr[FRAME_BITS-1];
  assign bits_left = cnt;
  assign rx_word   = sr[RX_BITS-1:0];

endmodule

// File: rtl/spi_sram_master.sv
// SPI (mode 0) master for a serial SRAM: opcode, address, data, MSB first,
// two clk cycles per SPI bit (SCK low then high).
// Ports:
//   clk, rstn                : system clock, synchronous active-low reset
//   bus (slave modport)      : host request/response bus
//   spi_select               : active-low chip select
//   spi_clk_out              : SPI clock, clk/2 while selected, low otherwise
//   spi_mosi, spi_miso       : serial data out / in
// Build option: SPI_RAM_MODE_INIT_EN sends WRMR 0x01,0x40 after each reset
// before the first request is accepted.
module spi_sram_master
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ADDR_BITS        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  spi_sram_master_if.slave bus,
  output logic             spi_select,
  output logic             spi_clk_out,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int DATA_BITS  = 8 * DATA_WIDTH_BYTES;
  localparam int FRAME_BITS = 8 + ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  // Bits still to go when the opcode / address phase has just finished.
  localparam logic [CNT_W-1:0] ADDR_LEFT = CNT_W'(ADDR_BITS + DATA_BITS);
  localparam logic [CNT_W-1:0] DATA_LEFT = CNT_W'(DATA_BITS);

  state_t                state, state_nxt;
  logic                  busy_q, busy_nxt;
  logic                  sel_q, sel_nxt;
  logic                  sclk_q, sclk_nxt;
  logic                  mosi_q, mosi_nxt;
  logic                  is_read_q, is_read_nxt;
  logic [DATA_BITS-1:0]  data_out_q;
  logic                  data_out_ld;
  logic                  ld, smp;
  logic [FRAME_BITS-1:0] ld_word;
  logic [CNT_W-1:0]      ld_bits;
  logic                  sh_bit;
  logic [CNT_W-1:0]      bits_left;
  logic [DATA_BITS-1:0]  rx_word;
`ifdef SPI_RAM_MODE_INIT_EN
  logic                  init_pending_q, init_pending_nxt;
`endif

  spi_bit_shifter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W),
    .RX_BITS    (DATA_BITS)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ld),
    .load_word (ld_word),
    .load_bits (ld_bits),
    .sample    (smp),
    .miso      (spi_miso),
    .mosi_bit  (sh_bit),
    .bits_left (bits_left),
    .rx_word   (rx_word)
  );

  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy_q;
    sel_nxt     = sel_q;
    sclk_nxt    = sclk_q;
    mosi_nxt    = mosi_q;
    is_read_nxt = is_read_q;
    data_out_ld = 1'b0;
    ld          = 1'b0;
    smp         = 1'b0;
    ld_word     = {OP_WRITE, bus.addr_in, bus.data_in};
    ld_bits     = CNT_W'(FRAME_BITS);
`ifdef SPI_RAM_MODE_INIT_EN
    init_pending_nxt = init_pending_q;
`endif
    case (state)
      IDLE: begin
`ifdef SPI_RAM_MODE_INIT_EN
        if (init_pending_q) begin
          init_pending_nxt = 1'b0;
          ld        = 1'b1;
          ld_word   = {OP_WRMR, SEQ_MODE, {(FRAME_BITS-16){1'b0}}};
          ld_bits   = CNT_W'(16);
          state_nxt = MODE_INIT;
          busy_nxt  = 1'b1;
          sel_nxt   = 1'b0;
          sclk_nxt  = 1'b0;
          mosi_nxt  = ld_word[FRAME_BITS-1];
        end else
`endif
        if (bus.start_write || bus.start_read) begin
          // Write wins a simultaneous request; the read is dropped.
          ld          = 1'b1;
          ld_word     = {(bus.start_write ? OP_WRITE : OP_READ),
                         bus.addr_in, bus.data_in};
          is_read_nxt = !bus.start_write;
          state_nxt   = CMD;
          busy_nxt    = 1'b1;
          sel_nxt     = 1'b0;
          sclk_nxt    = 1'b0;
          mosi_nxt    = ld_word[FRAME_BITS-1];
        end
      end
`ifdef SPI_RAM_MODE_INIT_EN
      MODE_INIT,
`endif
      CMD, ADDR, DATA: begin
        if (!sclk_q) begin
          // Rising SCK edge: sample miso and advance the frame.
          sclk_nxt = 1'b1;
          smp      = 1'b1;
        end else if (bits_left == '0) begin
          state_nxt   = DESEL;
          sel_nxt     = 1'b1;
          sclk_nxt    = 1'b0;
          mosi_nxt    = 1'b0;
          data_out_ld = is_read_q && (state == DATA);
        end else begin
          // Falling SCK edge: present the next bit.
          sclk_nxt = 1'b0;
          mosi_nxt = sh_bit;
          if (state == CMD && bits_left == ADDR_LEFT) begin
            state_nxt = ADDR;
          end else if (state == ADDR && bits_left == DATA_LEFT) begin
            state_nxt = DATA;
          end
        end
      end
      DESEL: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        sel_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      sel_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      is_read_q  <= 1'b0;
      data_out_q <= '0;
`ifdef SPI_RAM_MODE_INIT_EN
      init_pending_q <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      busy_q    <= busy_nxt;
      sel_q     <= sel_nxt;
      sclk_q    <= sclk_nxt;
      mosi_q    <= mosi_nxt;
      is_read_q <= is_read_nxt;
      if (data_out_ld) begin
        data_out_q <= rx_word;
      end
`ifdef SPI_RAM_MODE_INIT_EN
      init_pending_q <= init_pending_nxt;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.data_out = data_out_q;
  assign spi_select   = sel_q;
  assign spi_clk_out  = sclk_q;
  assign spi_mosi     = mosi_q;

endmodule
